// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchronizer plus per-bit tick-based debouncer with edge pulses
module switch_debounce #(
    parameter int WIDTH        = 18,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q, any_d;
    logic             tick;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    // A single cycle of agreement between s2 and the accepted level discards all progress.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]  = '0;
                    db_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_q   <= '0;
            s2_q   <= '0;
            pre_q  <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= sw_raw;
            s2_q   <= s1_q;
            pre_q  <= pre_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sw_db      = db_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - randomized and directed bench for switch_debounce against a behavioural model
module tb_switch_debounce;

    localparam int W = 18;
    localparam int D = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         any_change;

    always #5 clk = ~clk;

    switch_debounce #(.WIDTH(W), .TICK_DIV(D), .STABLE_TICKS(S)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .sw_raw     (sw_raw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .any_change (any_change)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: raw samples delayed through a two-entry queue, tick derived from cycles since reset,
    // and per bit the number of ticks seen while the delayed input disagrees with the accepted level.
    logic [W-1:0] hist [$];
    int           run [W];
    int           m_cyc = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_db = '0, m_rise = '0, m_fall = '0;
    logic         m_any = 1'b0;
    logic [W-1:0] m_s2;
    bit           m_tick;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            m_cyc = 0;
            for (int i = 0; i < W; i++) run[i] = 0;
            m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_s2   = hist.pop_front();
            hist.push_back(sw_raw);
            m_tick = ((m_cyc % D) == D - 1);
            m_cyc  = m_cyc + 1;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == m_db[i]) run[i] = 0;
                else if (m_tick) begin
                    run[i] = run[i] + 1;
                    if (run[i] == S) begin
                        run[i]  = 0;
                        m_db[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
            m_any = (m_rise != '0) || (m_fall != '0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (sw_db !== m_db || sw_rise !== m_rise || sw_fall !== m_fall || any_change !== m_any
                || (sw_rise & sw_fall) != '0) begin
                miscompares++;
                $display("FAIL model t=%0t: db=%h rise=%h fall=%h any=%b, expected db=%h rise=%h fall=%h any=%b",
                         $time, sw_db, sw_rise, sw_fall, any_change, m_db, m_rise, m_fall, m_any);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        vectors++;
        if (v < lo || v > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Number of falling edges until sw_db[idx] reaches val; 99 if it never does within the budget.
    task automatic wait_bit(input int idx, input logic val, output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sw_db[idx] === val) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        // Reset with all switches high
        sw_raw = 18'h3FFFF;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_db", 32'(sw_db), 32'h0);
            check("rst_rise", 32'(sw_rise), 32'h0);
            check("rst_fall", 32'(sw_fall), 32'h0);
            check("rst_any", 32'(any_change), 32'h0);
        end
        rst = 1'b0;
        wait_bit(0, 1'b1, lat);
        check("t1_latency", 32'(lat), 32'd12);
        check("t1_db", 32'(sw_db), 32'h3FFFF);
        check("t1_rise", 32'(sw_rise), 32'h3FFFF);
        check("t1_any", 32'(any_change), 32'h1);
        @(negedge clk);
        check("t1_rise_end", 32'(sw_rise), 32'h0);
        check("t1_any_end", 32'(any_change), 32'h0);

        // Clean step on bit 17
        sw_raw = '0;
        cycles(20);
        check("t2_base", 32'(sw_db), 32'h0);
        sw_raw[17] = 1'b1;
        wait_bit(17, 1'b1, lat);
        check_range("t2_latency", lat, 11, 14);
        check("t2_rise", 32'(sw_rise), 32'h20000);
        @(negedge clk);
        check("t2_rise_end", 32'(sw_rise), 32'h0);
        sw_raw = '0;
        cycles(20);

        // Bounce on bit 3
        for (int j = 0; j < 20; j++) begin
            sw_raw[3] = ~sw_raw[3];
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check("t3_db", 32'(sw_db[3]), 32'h0);
                check("t3_pulse", 32'(sw_rise[3] | sw_fall[3]), 32'h0);
            end
        end
        sw_raw[3] = 1'b0;
        cycles(20);
        check("t3_settled", 32'(sw_db), 32'h0);

        // Multi-bit step
        sw_raw[7:0] = 8'hA5;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sw_db[7:0] != 8'h00) begin lat = i; break; end
        end
        check_range("t4_rise_latency", lat, 11, 14);
        check("t4_db", 32'(sw_db[7:0]), 32'hA5);
        check("t4_rise", 32'(sw_rise[7:0]), 32'hA5);
        sw_raw[7:0] = 8'h00;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sw_db[7:0] != 8'hA5) begin lat = i; break; end
        end
        check_range("t4_fall_latency", lat, 11, 14);
        check("t4_db0", 32'(sw_db[7:0]), 32'h00);
        check("t4_fall", 32'(sw_fall[7:0]), 32'hA5);
        @(negedge clk);
        check("t4_fall_end", 32'(sw_fall[7:0]), 32'h00);
        cycles(20);

        // One-cycle glitch restarts qualification
        sw_raw[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_early", 32'(sw_db[0]), 32'h0);
        end
        sw_raw[0] = 1'b0;
        @(negedge clk);
        sw_raw[0] = 1'b1;
        wait_bit(0, 1'b1, lat);
        check_range("t5_latency", lat, 11, 14);
        sw_raw = '0;
        cycles(20);

        // Reset during a pending fall
        sw_raw[5] = 1'b1;
        cycles(20);
        check("t6_high", 32'(sw_db[5]), 32'h1);
        sw_raw[5] = 1'b0;
        cycles(5);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_db", 32'(sw_db), 32'h0);
        check("t6_rst_fall", 32'(sw_fall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_quiet_db", 32'(sw_db[5]), 32'h0);
            check("t6_quiet_any", 32'(any_change), 32'h0);
        end

        // Randomized sparse toggling, short bounces and occasional resets
        for (int n = 0; n < 150; n++) begin
            sw_raw = sw_raw ^ W'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
            else                           cycles($urandom_range(4, 30));
        end
        sw_raw = '0;
        cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the board slide switches.
- Synchronizes the raw, asynchronous SW inputs into the CLOCK_50 domain, then debounces each bit independently.
- Presents clean, stable levels to the downstream 8-bit 2-to-1 mux and display logic, which consume them as SW[17:0].
- Also provides one-cycle rise/fall pulses per bit for later labs that need edge events.

Parameters:
WIDTH, 18, number of switch bits conditioned.
TICK_DIV, 50000, prescaler period in clocks. 1 ms sample tick at 50 MHz. Legal range >= 2.
STABLE_TICKS, 16, consecutive ticks a new level must persist before it is accepted. Legal range >= 2.

Ports:
CLOCK_50  input  1  system clock, 50 MHz; all logic on the rising edge.
RESET  input  1  synchronous, active-high reset.
sw_raw  input  WIDTH  raw switch levels, asynchronous to CLOCK_50.
sw_db  output  WIDTH  debounced switch levels; feeds the mux as SW.
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0->1.
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1->0.
any_change  output  1  OR-reduction of sw_rise|sw_fall, registered in the same cycle.

Behaviour:
- Reset: while RESET is high at a clock edge, the following clear to 0:
  - both synchronizer flop rows
  - the prescaler
  - all per-bit counters
  - sw_db, sw_rise, sw_fall, any_change
- RESET has priority over every other event.
- After RESET deasserts, sw_db reads 0 even if switches are high; each high bit is re-qualified as a normal 0->1 change.
- Synchronizer: two flops per bit, sw_raw -> s1 -> s2. s2 is the only signal used downstream; no combinational path from sw_raw to any output.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps to 0
  - tick is high for exactly the one cycle in which the count equals TICK_DIV-1
- Per-bit counter cnt[i], width clog2(STABLE_TICKS):
  - If s2[i] == sw_db[i]: cnt[i] <= 0, whether or not there is a tick. Any single-cycle agreement discards progress; this is the glitch-reject rule.
  - Else if tick and cnt[i] < STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
  - Else if tick and cnt[i] == STABLE_TICKS-1: sw_db[i] <= s2[i], cnt[i] <= 0, and the matching rise/fall bit pulses high for exactly the next cycle.
  - Otherwise cnt[i] holds.
- Bits are fully independent. Any number of bits may change on the same tick; their pulses assert in the same cycle.
- sw_rise and sw_fall are never both high on the same bit.
- any_change is registered. It is high in exactly the cycles where any pulse bit is high.
- Latency from a clean sw_raw step (edge k) to the sw_db update:
  - minimum k + 3 + (STABLE_TICKS-1)*TICK_DIV
  - maximum k + 2 + STABLE_TICKS*TICK_DIV
  - exact value depends on prescaler phase
- Outputs hold their values indefinitely while inputs are stable; counters never overflow.

Test Plan:
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, so latency is 11..14 cycles.
1. Reset: hold RESET 3 cycles with sw_raw=18'h3FFFF -> sw_db=0, sw_rise=0, sw_fall=0, any_change=0 during reset. After release, sw_db becomes 18'h3FFFF within 14 cycles, sw_rise=18'h3FFFF for one cycle, any_change one pulse.
2. Clean step: sw_raw[17] 0->1 at edge k, held -> sw_db[17]=1 at an edge in k+11..k+14. sw_rise[17] high exactly 1 cycle. No other bits change.
3. Bounce: sw_raw[3] toggles every 2 cycles for 40 cycles, then settles at 0 -> sw_db[3] stays 0 throughout, no sw_rise/sw_fall pulse on bit 3.
4. Multi-bit: sw_raw[7:0] 8'h00 -> 8'hA5 in one cycle -> sw_db[7:0]=8'hA5 in a single cycle, sw_rise[7:0]=8'hA5 in that cycle. Then 8'hA5 -> 8'h00 -> sw_fall[7:0]=8'hA5 for one cycle.
5. One-cycle glitch mid-qualification: sw_raw[0] 0->1, then one cycle back at 0 after 6 cycles, then 1 again -> the count restarts. sw_db[0] rises 11..14 cycles after the final 0->1, not earlier.
6. Reset mid-operation: sw_db[5]=1, sw_raw[5] dropped to 0, RESET asserted 5 cycles later -> sw_db[5]=0 immediately after reset, no sw_fall[5] pulse. With sw_raw[5]=0, sw_db[5] stays 0 with no further pulses.
